// File: rtl/nn_layer_seq.sv
`default_nettype none
// ============================================================================
// Module      : nn_layer_seq
// Description : Time-multiplexed single-layer perceptron with a loadable
//               weight/threshold bank, shared saturating MAC, step activation.
// Revision    : 1.0  initial release
// ============================================================================
module nn_layer_seq #(
    parameter  int N_IN  = 4,
    parameter  int N_OUT = 4,
    parameter  int IN_W  = 1,
    parameter  int W_W   = 8,
    parameter  int ACC_W = 12,
    localparam int AW    = $clog2(N_OUT*(N_IN+1))
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [ACC_W-1:0]      cfg_wdata,
    input  logic                  start,
    input  logic [N_IN*IN_W-1:0]  x_in,
    output logic                  busy,
    output logic                  done,
    output logic [N_OUT-1:0]      y_out
);

    localparam int N_CFG = N_OUT*(N_IN+1);
    localparam int N_WT  = N_OUT*N_IN;
    localparam int WAW   = (N_WT  > 1) ? $clog2(N_WT)  : 1;
    localparam int NW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int IW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int PW    = IN_W + W_W + 1;
    localparam int SUM_W = ((ACC_W > PW) ? ACC_W : PW) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_ACT  = 2'd2;

    localparam logic [IW-1:0] c_I_LAST = IW'(N_IN-1);
    localparam logic [NW-1:0] c_N_LAST = NW'(N_OUT-1);
    localparam logic signed [SUM_W-1:0] c_ACC_MAX =
        {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] c_ACC_MIN =
        {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    logic signed [W_W-1:0]   w_q [N_WT];
    logic signed [ACC_W-1:0] t_q [N_OUT];

    logic [1:0]              state_q, state_d;
    logic [NW-1:0]           n_q, n_d;
    logic [IW-1:0]           i_q, i_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [N_IN*IN_W-1:0]    x_q, x_d;
    logic [N_OUT-1:0]        ybuf_q, ybuf_d;
    logic [N_OUT-1:0]        y_q, y_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [AW:0]             w_cfg_ext;
    logic [WAW-1:0]          w_widx;
    logic [IN_W-1:0]         w_x;
    logic signed [IN_W:0]    w_xs;
    logic signed [W_W-1:0]   w_wt;
    logic signed [PW-1:0]    w_prod;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_sat;
    logic                    w_fire;
    logic [N_OUT-1:0]        w_ybuf_set;

    // The bank is frozen while busy, so the running evaluation needs no shadow copy.
    assign w_cfg_ext = {1'b0, cfg_addr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_WT; k++)  w_q[k] <= '0;
            for (int k = 0; k < N_OUT; k++) t_q[k] <= ACC_W'(1);
        end else if (cfg_we && !busy_q) begin
            if (w_cfg_ext < (AW+1)'(N_WT))
                w_q[WAW'(cfg_addr)] <= cfg_wdata[W_W-1:0];
            else if (w_cfg_ext < (AW+1)'(N_CFG))
                t_q[NW'(cfg_addr - AW'(N_WT))] <= cfg_wdata;
        end
    end

    assign w_widx = WAW'(n_q) * WAW'(N_IN) + WAW'(i_q);
    assign w_x    = x_q[i_q*IN_W +: IN_W];
    assign w_xs   = {1'b0, w_x};
    assign w_wt   = w_q[w_widx];
    assign w_prod = w_xs * w_wt;
    assign w_sum  = {{(SUM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q}
                  + {{(SUM_W-PW){w_prod[PW-1]}}, w_prod};

    always_comb begin
        w_sat = w_sum[ACC_W-1:0];
        if (w_sum > c_ACC_MAX)      w_sat = c_ACC_MAX[ACC_W-1:0];
        else if (w_sum < c_ACC_MIN) w_sat = c_ACC_MIN[ACC_W-1:0];
    end

    assign w_fire = (acc_q >= t_q[n_q]);

    always_comb begin
        w_ybuf_set      = ybuf_q;
        w_ybuf_set[n_q] = w_fire;
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        i_d     = i_q;
        acc_d   = acc_q;
        x_d     = x_q;
        ybuf_d  = ybuf_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = x_in;
                    acc_d   = '0;
                    n_d     = '0;
                    i_d     = '0;
                    busy_d  = 1'b1;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = w_sat;
                if (i_q == c_I_LAST) state_d = S_ACT;
                else                 i_d     = i_q + IW'(1);
            end
            S_ACT: begin
                ybuf_d = w_ybuf_set;
                if (n_q == c_N_LAST) begin
                    y_d     = w_ybuf_set;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    n_d     = n_q + NW'(1);
                    i_d     = '0;
                    acc_d   = '0;
                    state_d = S_MAC;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            i_q     <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            ybuf_q  <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            i_q     <= i_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            ybuf_q  <= ybuf_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign y_out = y_q;

endmodule
`default_nettype wire

// File: tb/tb_nn_layer_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_nn_layer_seq
// Description : Directed bench; dut uses default parameters, dut_s has IN_W=4.
// Revision    : 1.0  initial release
// ============================================================================
module tb_nn_layer_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [11:0] cfg_wdata;
    logic        start;
    logic [3:0]  x_a;
    logic [15:0] x_b;
    logic        busy_a, done_a, busy_b, done_b;
    logic [3:0]  y_a, y_b;
    logic        sel;
    logic        busy_o, done_o;
    logic [3:0]  y_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nn_layer_seq dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .start(start), .x_in(x_a),
        .busy(busy_a), .done(done_a), .y_out(y_a)
    );

    nn_layer_seq #(.IN_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .start(start), .x_in(x_b),
        .busy(busy_b), .done(done_b), .y_out(y_b)
    );

    assign busy_o = sel ? busy_b : busy_a;
    assign done_o = sel ? done_b : done_a;
    assign y_o    = sel ? y_b    : y_a;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at a falling edge.
    task automatic wr(input int addr, input int data);
        cfg_we    = 1'b1;
        cfg_addr  = 5'(addr);
        cfg_wdata = 12'(data);
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    // Starts an evaluation (optionally with a config write in the same cycle) and
    // returns at the falling edge where busy has dropped.
    task automatic run(input logic [15:0] x, input bit cw, input int a, input int d,
                       input int disturb_at, output logic b0, output logic [3:0] y,
                       output int cyc, output logic dn);
        x_a = x[3:0]; x_b = x;
        start = 1'b1; cfg_we = cw; cfg_addr = 5'(a); cfg_wdata = 12'(d);
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0;
        b0  = busy_o;
        cyc = 0;
        while (busy_o && cyc < 200) begin
            if (cyc == disturb_at) begin
                start = 1'b1; cfg_we = 1'b1; cfg_addr = 5'd0; cfg_wdata = 12'hF9C;
                x_a = ~x_a; x_b = ~x_b;
            end else begin
                start = 1'b0; cfg_we = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; cfg_we = 1'b0;
        y  = y_o;
        dn = done_o;
    endtask

    task automatic idle_watch(input int n, output int nd, output int nb);
        nd = 0; nb = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (done_o) nd++;
            if (busy_o) nb++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       b0, dn;
        logic [3:0] y;
        int         cyc, nd, nb;
        int         wref[16] = '{2,4,2,1, 1,2,3,4, 1,2,4,2, 1,4,2,5};

        sel = 1'b0; rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0; x_a = '0; x_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_y", y_o, 4'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run(16'h000F, 0, 0, 0, -1, b0, y, cyc, dn);
        chk("dflt_busy_rise", b0, 1'b1);
        chk("dflt_cycles", cyc, 20);
        chk("dflt_done", dn, 1'b1);
        chk("dflt_y", y, 4'b0000);
        @(negedge clk);
        chk("dflt_done_pulse", done_o, 1'b0);

        for (int k = 0; k < 16; k++) wr(k, wref[k]);
        for (int k = 16; k < 20; k++) wr(k, 2);
        run(16'h0001, 0, 0, 0, -1, b0, y, cyc, dn);
        chk("ref_x1_y", y, 4'b0001);
        run(16'h0002, 0, 0, 0, -1, b0, y, cyc, dn);
        chk("ref_x2_y", y, 4'b1111);
        chk("ref_x2_done", dn, 1'b1);

        run(16'h0002, 0, 0, 0, 5, b0, y, cyc, dn);
        chk("ign_cycles", cyc, 20);
        chk("ign_done", dn, 1'b1);
        chk("ign_y", y, 4'b1111);
        idle_watch(25, nd, nb);
        chk("ign_extra_done", nd, 0);
        chk("ign_extra_busy", nb, 0);
        run(16'h0001, 0, 0, 0, -1, b0, y, cyc, dn);
        chk("ign_w00_kept", y, 4'b0001);

        for (int k = 20; k < 32; k++) wr(k, 12'h7FF);
        run(16'h0001, 0, 0, 0, -1, b0, y, cyc, dn);
        chk("oor_y", y, 4'b0001);

        run(16'h0002, 1, 16, 9, -1, b0, y, cyc, dn);
        chk("cfg_start_y", y, 4'b1110);
        chk("cfg_start_done", dn, 1'b1);
        run(16'h0001, 0, 0, 0, -1, b0, y, cyc, dn);
        chk("b2b_busy_rise", b0, 1'b1);
        chk("b2b_cycles", cyc, 20);
        chk("b2b_y", y, 4'b0000);

        wr(16, 2);
        run(16'h0002, 0, 0, 0, -1, b0, y, cyc, dn);
        chk("pre_rst_y", y, 4'b1111);
        x_a = 4'h2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_busy_before", busy_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_y", y_o, 4'h0);
        chk("mid_rst_done", done_o, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_watch(30, nd, nb);
        chk("post_rst_done", nd, 0);
        chk("post_rst_busy", nb, 0);
        run(16'h000F, 0, 0, 0, -1, b0, y, cyc, dn);
        chk("post_rst_y", y, 4'b0000);
        chk("post_rst_cycles", cyc, 20);

        sel = 1'b1;
        for (int k = 0; k < 4; k++) wr(k, 127);
        wr(16, 2047);
        run(16'hFFFF, 0, 0, 0, -1, b0, y, cyc, dn);
        chk("sat_pos_y", y, 4'b0001);
        for (int k = 0; k < 4; k++) wr(k, 12'hF80);
        wr(16, 12'h800);
        run(16'hFFFF, 0, 0, 0, -1, b0, y, cyc, dn);
        chk("sat_neg_min_y", y, 4'b0001);
        wr(16, 12'h801);
        run(16'hFFFF, 0, 0, 0, -1, b0, y, cyc, dn);
        chk("sat_neg_above_y", y, 4'b0000);
        chk("sat_cycles", cyc, 20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
